// File: rtl/flr_issue.sv
// flr_issue: Tomasulo front end. Holds the architectural register file with
// per-register producer tags, decodes one instruction at a time, issues it to
// the add or mul reservation station with operand values or tags, renames the
// destination to the granted station tag, and retires CDB results.
//
// Ports:
//   clk, rst                    clock (rising edge), async active-high reset
//   instr_valid, instr          instruction offer: [31:26] op, [25:21] src1,
//                               [20:16] src2, [15:11] dest
//   instr_ready                 issue unit idle and able to accept
//   iss_add_valid/iss_mul_valid issue request to add / mul station
//   iss_tag1/2, iss_data1/2     operand tags (all-ones = data valid) and data
//   iss_dest                    destination register index
//   rs_grant, rs_grant_tag      station acceptance and allocated tag
//   cdb_valid/tag/data          result broadcast
//   dbg_addr, dbg_data, dbg_tag combinational register file read port
//   illegal                     sticky error flag (bad opcode or bad grant tag)
module flr_issue #(
    parameter int unsigned NREG = 32,
    parameter int unsigned DW   = 32,
    parameter int unsigned TW   = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          instr_valid,
    input  logic [31:0]   instr,
    output logic          instr_ready,
    output logic          iss_add_valid,
    output logic          iss_mul_valid,
    output logic [TW-1:0] iss_tag1,
    output logic [TW-1:0] iss_tag2,
    output logic [DW-1:0] iss_data1,
    output logic [DW-1:0] iss_data2,
    output logic [4:0]    iss_dest,
    input  logic          rs_grant,
    input  logic [TW-1:0] rs_grant_tag,
    input  logic          cdb_valid,
    input  logic [TW-1:0] cdb_tag,
    input  logic [DW-1:0] cdb_data,
    input  logic [4:0]    dbg_addr,
    output logic [DW-1:0] dbg_data,
    output logic [TW-1:0] dbg_tag,
    output logic          illegal
);

    localparam int unsigned AW       = 5;
    localparam logic [TW-1:0] TAG_NONE = '1;
    localparam logic [5:0]  OP_ADD   = 6'b001000;
    localparam logic [5:0]  OP_MUL   = 6'b111111;

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } state_t;

    state_t state, state_nxt;

    logic [DW-1:0] reg_val [NREG];
    logic [TW-1:0] reg_tag [NREG];

    logic          add_valid_nxt, mul_valid_nxt;
    logic [TW-1:0] tag1_nxt, tag2_nxt;
    logic [DW-1:0] data1_nxt, data2_nxt;
    logic [AW-1:0] dest_nxt;
    logic          illegal_nxt;
    logic          rename_en;

    logic [5:0]    opcode;
    logic [AW-1:0] src1, src2;
    logic [TW-1:0] op1_tag, op2_tag;
    logic [DW-1:0] op1_data, op2_data;
    logic          cdb_live;
    logic          grant_in_range;
    logic          unused_instr;

    assign opcode       = instr[31:26];
    assign src1         = instr[25:21];
    assign src2         = instr[20:16];
    assign unused_instr = ^instr[10:0];
    assign cdb_live     = cdb_valid && (cdb_tag != TAG_NONE);
    assign instr_ready  = (state == IDLE);

    // Add station owns tags 8..15, mul station owns tags 0..7.
    assign grant_in_range = iss_add_valid ? (rs_grant_tag[TW-1:3] == (TW-3)'(1))
                                          : (rs_grant_tag[TW-1:3] == (TW-3)'(0));

    // Operand read with same-cycle CDB bypass; r0 is hardwired to 0 / no producer.
    always_comb begin
        op1_tag  = TAG_NONE;
        op1_data = '0;
        op2_tag  = TAG_NONE;
        op2_data = '0;
        if (src1 != AW'(0)) begin
            if (reg_tag[src1] == TAG_NONE) begin
                op1_data = reg_val[src1];
            end else if (cdb_live && (cdb_tag == reg_tag[src1])) begin
                op1_data = cdb_data;
            end else begin
                op1_tag = reg_tag[src1];
            end
        end
        if (src2 != AW'(0)) begin
            if (reg_tag[src2] == TAG_NONE) begin
                op2_data = reg_val[src2];
            end else if (cdb_live && (cdb_tag == reg_tag[src2])) begin
                op2_data = cdb_data;
            end else begin
                op2_tag = reg_tag[src2];
            end
        end
    end

    // Debug read port.
    always_comb begin
        dbg_data = '0;
        dbg_tag  = TAG_NONE;
        if (dbg_addr != AW'(0)) begin
            dbg_data = reg_val[dbg_addr];
            dbg_tag  = reg_tag[dbg_addr];
        end
    end

    // State register and registered issue outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            iss_add_valid <= 1'b0;
            iss_mul_valid <= 1'b0;
            iss_tag1      <= TAG_NONE;
            iss_tag2      <= TAG_NONE;
            iss_data1     <= '0;
            iss_data2     <= '0;
            iss_dest      <= '0;
            illegal       <= 1'b0;
        end else begin
            state         <= state_nxt;
            iss_add_valid <= add_valid_nxt;
            iss_mul_valid <= mul_valid_nxt;
            iss_tag1      <= tag1_nxt;
            iss_tag2      <= tag2_nxt;
            iss_data1     <= data1_nxt;
            iss_data2     <= data2_nxt;
            iss_dest      <= dest_nxt;
            illegal       <= illegal_nxt;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_nxt     = state;
        add_valid_nxt = iss_add_valid;
        mul_valid_nxt = iss_mul_valid;
        tag1_nxt      = iss_tag1;
        tag2_nxt      = iss_tag2;
        data1_nxt     = iss_data1;
        data2_nxt     = iss_data2;
        dest_nxt      = iss_dest;
        illegal_nxt   = illegal;
        rename_en     = 1'b0;
        case (state)
            IDLE: begin
                if (instr_valid) begin
                    if ((opcode == OP_ADD) || (opcode == OP_MUL)) begin
                        add_valid_nxt = (opcode == OP_ADD);
                        mul_valid_nxt = (opcode == OP_MUL);
                        tag1_nxt      = op1_tag;
                        tag2_nxt      = op2_tag;
                        data1_nxt     = op1_data;
                        data2_nxt     = op2_data;
                        dest_nxt      = instr[15:11];
                        state_nxt     = ISSUE;
                    end else begin
                        illegal_nxt = 1'b1;
                    end
                end
            end
            ISSUE: begin
                // Operands still waiting on a producer snoop the CDB.
                if (cdb_live && (iss_tag1 != TAG_NONE) && (iss_tag1 == cdb_tag)) begin
                    tag1_nxt  = TAG_NONE;
                    data1_nxt = cdb_data;
                end
                if (cdb_live && (iss_tag2 != TAG_NONE) && (iss_tag2 == cdb_tag)) begin
                    tag2_nxt  = TAG_NONE;
                    data2_nxt = cdb_data;
                end
                if (rs_grant) begin
                    add_valid_nxt = 1'b0;
                    mul_valid_nxt = 1'b0;
                    state_nxt     = IDLE;
                    if (grant_in_range) begin
                        rename_en = 1'b1;
                    end else begin
                        illegal_nxt = 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Register file: CDB retire, then rename (rename overrides the tag on the same dest).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                reg_val[i] <= '0;
                reg_tag[i] <= TAG_NONE;
            end
        end else begin
            for (int unsigned i = 1; i < NREG; i++) begin
                if (cdb_live && (reg_tag[i] == cdb_tag)) begin
                    reg_val[i] <= cdb_data;
                    reg_tag[i] <= TAG_NONE;
                end
                if (rename_en && (iss_dest == AW'(i))) begin
                    reg_tag[i] <= rs_grant_tag;
                end
            end
        end
    end

endmodule

// File: tb/tb_flr_issue.sv
// Directed testbench for flr_issue: hand-computed expectations for issue,
// rename, CDB retire/capture/bypass, stall, illegal cases and async reset.
module tb_flr_issue;

    localparam logic [5:0] OP_ADD = 6'b001000;
    localparam logic [5:0] OP_MUL = 6'b111111;
    localparam logic [5:0] OP_BAD = 6'b000001;

    logic        clk;
    logic        rst;
    logic        instr_valid;
    logic [31:0] instr;
    logic        instr_ready;
    logic        iss_add_valid;
    logic        iss_mul_valid;
    logic [4:0]  iss_tag1, iss_tag2;
    logic [31:0] iss_data1, iss_data2;
    logic [4:0]  iss_dest;
    logic        rs_grant;
    logic [4:0]  rs_grant_tag;
    logic        cdb_valid;
    logic [4:0]  cdb_tag;
    logic [31:0] cdb_data;
    logic [4:0]  dbg_addr;
    logic [31:0] dbg_data;
    logic [4:0]  dbg_tag;
    logic        illegal;

    int n_vec;
    int n_err;

    flr_issue dut (
        .clk           (clk),
        .rst           (rst),
        .instr_valid   (instr_valid),
        .instr         (instr),
        .instr_ready   (instr_ready),
        .iss_add_valid (iss_add_valid),
        .iss_mul_valid (iss_mul_valid),
        .iss_tag1      (iss_tag1),
        .iss_tag2      (iss_tag2),
        .iss_data1     (iss_data1),
        .iss_data2     (iss_data2),
        .iss_dest      (iss_dest),
        .rs_grant      (rs_grant),
        .rs_grant_tag  (rs_grant_tag),
        .cdb_valid     (cdb_valid),
        .cdb_tag       (cdb_tag),
        .cdb_data      (cdb_data),
        .dbg_addr      (dbg_addr),
        .dbg_data      (dbg_data),
        .dbg_tag       (dbg_tag),
        .illegal       (illegal)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [5:0] op, input logic [4:0] s1, input logic [4:0] s2,
                         input logic [4:0] d);
        instr       = {op, s1, s2, d, 11'b0};
        instr_valid = 1'b1;
        tick();
        instr_valid = 1'b0;
    endtask

    task automatic grant(input logic [4:0] t);
        rs_grant     = 1'b1;
        rs_grant_tag = t;
        tick();
        rs_grant     = 1'b0;
    endtask

    task automatic cdb(input logic [4:0] t, input logic [31:0] d);
        cdb_valid = 1'b1;
        cdb_tag   = t;
        cdb_data  = d;
        tick();
        cdb_valid = 1'b0;
    endtask

    task automatic dbg(input string nm, input logic [4:0] a, input logic [31:0] d,
                       input logic [4:0] t);
        dbg_addr = a;
        #1;
        check({nm, "_data"}, dbg_data, d);
        check({nm, "_tag"}, 32'(dbg_tag), 32'(t));
    endtask

    task automatic req(input string nm, input logic add, input logic mul,
                       input logic [4:0] t1, input logic [31:0] d1,
                       input logic [4:0] t2, input logic [31:0] d2);
        check({nm, "_add"}, 32'(iss_add_valid), 32'(add));
        check({nm, "_mul"}, 32'(iss_mul_valid), 32'(mul));
        check({nm, "_tag1"}, 32'(iss_tag1), 32'(t1));
        check({nm, "_data1"}, iss_data1, d1);
        check({nm, "_tag2"}, 32'(iss_tag2), 32'(t2));
        check({nm, "_data2"}, iss_data2, d2);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst = 1'b1;
        instr_valid = 1'b0;
        instr = '0;
        rs_grant = 1'b0;
        rs_grant_tag = '0;
        cdb_valid = 1'b0;
        cdb_tag = '0;
        cdb_data = '0;
        dbg_addr = '0;
        tick();

        // Reset state
        check("rst_ready", 32'(instr_ready), 32'd1);
        req("rst", 1'b0, 1'b0, 5'h1f, 32'd0, 5'h1f, 32'd0);
        check("rst_dest", 32'(iss_dest), 32'd0);
        check("rst_illegal", 32'(illegal), 32'd0);
        dbg("rst_r5", 5'd5, 32'd0, 5'h1f);
        rst = 1'b0;
        tick();

        // Preset producers: r1 <- tag 8 (add), r2 <- tag 0 (mul)
        issue(OP_ADD, 5'd0, 5'd0, 5'd1);
        check("pre1_ready", 32'(instr_ready), 32'd0);
        check("pre1_dest", 32'(iss_dest), 32'd1);
        req("pre1", 1'b1, 1'b0, 5'h1f, 32'd0, 5'h1f, 32'd0);
        grant(5'd8);
        check("pre1_ready_after", 32'(instr_ready), 32'd1);
        dbg("pre1_r1", 5'd1, 32'd0, 5'd8);
        issue(OP_MUL, 5'd0, 5'd0, 5'd2);
        check("pre2_mul", 32'(iss_mul_valid), 32'd1);
        grant(5'd0);
        dbg("pre2_r2", 5'd2, 32'd0, 5'd0);
        cdb(5'd8, 32'd5);
        cdb(5'd0, 32'd7);
        dbg("wb_r1", 5'd1, 32'd5, 5'h1f);
        dbg("wb_r2", 5'd2, 32'd7, 5'h1f);

        // add r3 = r1 + r2
        issue(OP_ADD, 5'd1, 5'd2, 5'd3);
        req("add3", 1'b1, 1'b0, 5'h1f, 32'd5, 5'h1f, 32'd7);
        check("add3_dest", 32'(iss_dest), 32'd3);
        grant(5'd9);
        dbg("add3_r3", 5'd3, 32'd0, 5'd9);

        // mul r4 = r3 * r3 with r3 pending on tag 9; CDB capture while stalled
        issue(OP_MUL, 5'd3, 5'd3, 5'd4);
        req("mul4", 1'b0, 1'b1, 5'd9, 32'd0, 5'd9, 32'd0);
        cdb(5'd9, 32'd12);
        req("mul4_cap", 1'b0, 1'b1, 5'h1f, 32'd12, 5'h1f, 32'd12);
        dbg("ret_r3", 5'd3, 32'd12, 5'h1f);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("stall_ready", 32'(instr_ready), 32'd0);
            check("stall_mul", 32'(iss_mul_valid), 32'd1);
            check("stall_data1", iss_data1, 32'd12);
        end
        grant(5'd2);
        check("mul4_ready_after", 32'(instr_ready), 32'd1);
        check("mul4_mul_after", 32'(iss_mul_valid), 32'd0);
        dbg("mul4_r4", 5'd4, 32'd0, 5'd2);

        // add r5 = r4 + r1, granted with out-of-range tag 3
        issue(OP_ADD, 5'd4, 5'd1, 5'd5);
        req("add5", 1'b1, 1'b0, 5'd2, 32'd0, 5'h1f, 32'd5);
        check("add5_illegal_pre", 32'(illegal), 32'd0);
        grant(5'd3);
        check("add5_illegal", 32'(illegal), 32'd1);
        check("add5_ready", 32'(instr_ready), 32'd1);
        dbg("add5_r5", 5'd5, 32'd0, 5'h1f);

        // Rename r3 to 10 in the same cycle CDB retires r3's old tag 9
        issue(OP_ADD, 5'd0, 5'd0, 5'd3);
        grant(5'd9);
        dbg("ren_r3_pre", 5'd3, 32'd12, 5'd9);
        issue(OP_ADD, 5'd0, 5'd0, 5'd3);
        cdb_valid = 1'b1;
        cdb_tag = 5'd9;
        cdb_data = 32'd77;
        grant(5'd10);
        cdb_valid = 1'b0;
        dbg("ren_r3", 5'd3, 32'd77, 5'd10);

        // Same-cycle bypass: r1 pending on 12, CDB {12,42} during acceptance
        issue(OP_ADD, 5'd0, 5'd0, 5'd1);
        grant(5'd12);
        cdb_valid = 1'b1;
        cdb_tag = 5'd12;
        cdb_data = 32'd42;
        issue(OP_ADD, 5'd1, 5'd0, 5'd6);
        cdb_valid = 1'b0;
        req("byp", 1'b1, 1'b0, 5'h1f, 32'd42, 5'h1f, 32'd0);
        grant(5'd13);
        dbg("byp_r1", 5'd1, 32'd42, 5'h1f);
        dbg("byp_r6", 5'd6, 32'd0, 5'd13);

        // add r5 = r0 + r3, then async reset mid-ISSUE
        issue(OP_ADD, 5'd0, 5'd3, 5'd5);
        req("add_r0", 1'b1, 1'b0, 5'h1f, 32'd0, 5'd10, 32'd0);
        #2;
        rst = 1'b1;
        #1;
        check("arst_add", 32'(iss_add_valid), 32'd0);
        check("arst_ready", 32'(instr_ready), 32'd1);
        check("arst_illegal", 32'(illegal), 32'd0);
        check("arst_tag2", 32'(iss_tag2), 32'h1f);
        for (int r = 0; r < 32; r++) begin
            dbg("arst_reg", 5'(r), 32'd0, 5'h1f);
        end
        tick();
        rst = 1'b0;
        tick();

        // cdb_tag all-ones is not a producer
        cdb(5'h1f, 32'd99);
        dbg("cdb_none_r2", 5'd2, 32'd0, 5'h1f);

        // Illegal opcode
        issue(OP_BAD, 5'd1, 5'd2, 5'd7);
        check("bad_illegal", 32'(illegal), 32'd1);
        check("bad_add", 32'(iss_add_valid), 32'd0);
        check("bad_mul", 32'(iss_mul_valid), 32'd0);
        check("bad_ready", 32'(instr_ready), 32'd1);
        dbg("bad_r7", 5'd7, 32'd0, 5'h1f);

        // Rename of r0 is ignored
        issue(OP_ADD, 5'd0, 5'd0, 5'd0);
        check("r0_add", 32'(iss_add_valid), 32'd1);
        grant(5'd8);
        dbg("r0_ren", 5'd0, 32'd0, 5'h1f);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/flr_issue.md
Name: flr_issue

Overview:
- Front end of the Tomasulo pipeline. Holds the architectural register file (FLR) together with a per-register producer tag.
- Decodes one instruction at a time and issues it to the add or mul reservation station with operand values or operand tags.
- Renames the destination register to the tag that the station allocates.
- Retires broadcast results (CDB) back into the register file.
- Acts as the sending end of the FLR→RS issue interface and the receiving end of the RS/FU→FLR result path.

Parameters:
- NREG, 32, number of architectural registers (index width 5).
- DW, 32, data width.
- TW, 5, tag width. The all-ones value 5'b11111 means "value ready / no producer".

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- instr_valid  in  1  instruction offered.
- instr  in  32  fields: [31:26] opcode, [25:21] src1, [20:16] src2, [15:11] dest.
- instr_ready  out  1  issue unit can accept an instruction.
- iss_add_valid  out  1  issue request to the add RS.
- iss_mul_valid  out  1  issue request to the mul RS.
- iss_tag1, iss_tag2  out  5 each  operand tags; 5'b11111 means the matching data field is valid.
- iss_data1, iss_data2  out  32 each  operand values; 0 when the matching tag is not 5'b11111.
- iss_dest  out  5  destination register index.
- rs_grant  in  1  station accepted the request; rs_grant_tag is valid in this cycle.
- rs_grant_tag  in  5  allocated tag: add RS uses 8..15, mul RS uses 0..7.
- cdb_valid  in  1  result broadcast.
- cdb_tag  in  5  producer tag of the result.
- cdb_data  in  32  result value.
- dbg_addr  in  5  debug read index.
- dbg_data  out  32  combinational read of the register value.
- dbg_tag  out  5  combinational read of the register tag.
- illegal  out  1  sticky error flag; cleared only by rst.

Behaviour:
- Reset (async, immediate):
  - All register values go to 0 and all tags to 5'b11111.
  - FSM goes to IDLE; instr_ready=1; iss_*_valid=0; iss_tag*=5'b11111; iss_data*=0; iss_dest=0; illegal=0.
  - Reset in ISSUE drops the request in the same instant; nothing is renamed.
- Register r0 always reads value 0 with tag 5'b11111. Writes and renames targeting r0 are ignored.
- Decode: opcode 6'b001000 is add; opcode 6'b111111 is mul.
  - Any other opcode with instr_valid in IDLE is consumed in one cycle: illegal is set, no issue, FSM stays in IDLE.
- FSM has two states, IDLE and ISSUE.
- IDLE:
  - instr_ready=1.
  - On instr_valid with a legal opcode: latch dest, unit and both operands, then go to ISSUE.
  - Operand read: if the register tag is 5'b11111, take the value. Otherwise take the tag.
  - Same-cycle bypass: if cdb_valid and cdb_tag equals the register tag, use cdb_data and tag 5'b11111.
- ISSUE:
  - instr_ready=0. Exactly one of iss_add_valid / iss_mul_valid is 1. All iss_* outputs are registered and stable except for the CDB capture below.
  - CDB capture: each cycle, a latched operand tag (not 5'b11111) that equals cdb_tag with cdb_valid becomes 5'b11111 with data=cdb_data from the next cycle.
  - On rs_grant: if rs_grant_tag is in range for the unit, set tag[dest]<=rs_grant_tag. If out of range, set illegal and do not rename. In both cases return to IDLE.
  - Without rs_grant the request is held indefinitely; the station is full.
- Throughput: at most one instruction every 2 cycles. Issue latency is 1 cycle from acceptance to valid.
- CDB retire: every cycle, each register r≠0 whose tag equals cdb_tag (cdb_valid=1) gets value<=cdb_data and tag<=5'b11111. Multiple registers may match.
  - cdb_tag=5'b11111 is ignored.
- Simultaneous rename and CDB on the same dest: the rename wins and tag becomes rs_grant_tag. The value takes cdb_data if the old tag matched, which is harmless.
- Source equals dest (e.g. r3=r3+r4): operands are captured before the rename, so the instruction sees the old producer.

Test Plan:
- Reset, then write r1=5, r2=7 via CDB (tags preset by prior issues), then issue add r3=r1+r2 → iss_add_valid=1 next cycle, tags 11111/11111, data 5/7; grant tag 9 → dbg_tag(r3)=9; CDB {9, 12} → r3=12, tag 11111.
- mul r4=r3*r3 while r3 has tag 9 → iss_tag1=iss_tag2=9; CDB {9, 12} during ISSUE with no grant → next cycle tags 11111, data 12/12.
- Grant held low for 10 cycles → request stable, instr_ready=0 throughout; grant on cycle 11 → instr_ready=1 in the following cycle.
- Opcode 6'b000001 → illegal=1, no iss_*_valid. Add granted with tag 3 → illegal=1, dest tag unchanged.
- CDB {9, X} in the same cycle that r3 is renamed to 10 → r3 tag=10. add r5=r0+r3 → operand1 data 0 with tag 11111.
- Assert rst mid-ISSUE → iss_add_valid=0 immediately; all dbg_tag=11111 and dbg_data=0.
